// File: rtl/shift_reg_universal.sv
// Universal shift register with a self-timed LSB-first serialiser.
// Modes: hold, shift right, shift left, parallel load. A start pulse in IDLE
// loads par_in and shifts it out over exactly WIDTH cycles with busy/done.
module shift_reg_universal #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  // Bit counter is sized from WIDTH; never overridden from outside.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;

  // Shifted views of q: shr_vec takes ser_in_l at the MSB, shl_vec takes
  // ser_in_r at the LSB. The serialiser reuses shr_vec.
  logic [WIDTH-1:0] shr_vec;
  logic [WIDTH-1:0] shl_vec;

  assign shr_vec[WIDTH-1] = ser_in_l;
  assign shl_vec[0]       = ser_in_r;

  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shr_vec[gi]     = q_reg[gi+1];
      assign shl_vec[gi + 1] = q_reg[gi];
    end
  endgenerate

  // State, data, counter and done registers; reset_n aborts any frame at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: clr > start (IDLE) > serial shift (SHIFT) > mode.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;

    if (clr) begin
      state_next = IDLE;
      q_next     = '0;
      cnt_next   = '0;
    end else if (state_reg == IDLE && start) begin
      state_next = SHIFT;
      q_next     = par_in;
      cnt_next   = '0;
    end else if (state_reg == SHIFT) begin
      q_next = shr_vec;
      if (cnt_reg == CNT_LAST) begin
        // Final bit has been on ser_out_r this cycle; close the frame.
        state_next = IDLE;
        cnt_next   = '0;
        done_next  = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_SHR:  q_next = shr_vec;
        MODE_SHL:  q_next = shl_vec;
        MODE_LOAD: q_next = par_in;
        default:   q_next = q_reg;
      endcase
    end
  end

  assign par_out   = q_reg;
  assign ser_out_r = q_reg[0];
  assign ser_out_l = q_reg[WIDTH-1];
  assign busy      = (state_reg == SHIFT);
  assign done      = done_reg;

endmodule
